// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine between NUM_REQ byte-stream requesters.
// Round-robin grant held per packet, with an optional source-header byte per packet.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter bit          HDR_EN       = 1'b1,
  parameter logic [7:0]  HDR_BASE     = 8'hA0,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx_start,
  output logic [7:0]                 uart_byte,
  input  logic                       uart_tx_busy,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StLaunchHdr  = 3'd1;
  localparam logic [2:0] StLaunchData = 3'd2;
  localparam logic [2:0] StWaitBusy   = 3'd3;
  localparam logic [2:0] StWaitDone   = 3'd4;
  localparam logic [2:0] StWaitData   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  rr_q, rr_d;
  logic            active_q, active_d;
  logic            pkt_end_q, pkt_end_d;
  logic [7:0]      byte_q, byte_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdW-1:0]  pick;
  logic            pick_found;
  logic            g_valid, g_last;
  logic [7:0]      g_data, hdr_byte;

  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign g_data   = req_data[{grant_q, 3'b000} +: 8];
  assign hdr_byte = HDR_BASE | {{(8 - IdW){1'b0}}, grant_q};

  assign grant_id     = grant_q;
  assign grant_active = active_q;

  // First valid requester strictly after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!pick_found && req_valid[IdW'(idx)]) begin
        pick       = IdW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    active_d      = active_q;
    pkt_end_d     = pkt_end_q;
    byte_d        = byte_q;
    cnt_d         = cnt_q;
    uart_tx_start = 1'b0;
    uart_byte     = byte_q;
    req_ready     = '0;
    err_timeout   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d  = pick;
          active_d = 1'b1;
          state_d  = HDR_EN ? StLaunchHdr : StLaunchData;
        end
      end
      StLaunchHdr: begin
        uart_byte     = hdr_byte;
        uart_tx_start = 1'b1;
        byte_d        = hdr_byte;
        pkt_end_d     = 1'b0;
        cnt_d         = '0;
        state_d       = StWaitBusy;
      end
      StLaunchData: begin
        uart_byte          = g_data;
        uart_tx_start      = 1'b1;
        req_ready[grant_q] = 1'b1;
        byte_d             = g_data;
        pkt_end_d          = g_last;
        cnt_d              = '0;
        state_d            = StWaitBusy;
      end
      StWaitBusy: begin
        if (uart_tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntLast) begin
          // Engine never responded: drop the rest of the packet and re-arbitrate.
          err_timeout = 1'b1;
          active_d    = 1'b0;
          rr_d        = grant_q;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          if (pkt_end_q) begin
            active_d = 1'b0;
            rr_d     = grant_q;
            state_d  = StIdle;
          end else if (g_valid) begin
            state_d = StLaunchData;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (g_valid) state_d = StLaunchData;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_q      <= IdW'(NUM_REQ - 1);
      active_q  <= 1'b0;
      pkt_end_q <= 1'b0;
      byte_q    <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      active_q  <= active_d;
      pkt_end_q <= pkt_end_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity. A grant is held from a requester's first byte through its req_last byte.
- Drives the engine's tx_start/byte_to_send inputs and sequences each byte off the engine's tx_busy flag.
- Optionally prefixes every packet with a header byte identifying the source. Sits between client logic and the UART transmitter in the UART core.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HDR_EN, 1, 1 = send header byte (HDR_BASE | requester index) before each packet's data.
- HDR_BASE, 8'hA0, header base value; low 4 bits must be 0.
- BUSY_TIMEOUT, 64, max clk cycles from uart_tx_start until uart_tx_busy must be seen high.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-high reset.
- req_valid, input, NUM_REQ, per-requester byte available.
- req_data, input, 8*NUM_REQ, per-requester byte; requester i uses bits [8i+7:8i].
- req_last, input, NUM_REQ, per-requester "this byte ends the packet".
- req_ready, output, NUM_REQ, one-cycle pulse: byte consumed from the granted requester.
- uart_tx_start, output, 1, one-cycle launch pulse to the UART transmitter.
- uart_byte, output, 8, byte to the transmitter; stable from launch until busy falls.
- uart_tx_busy, input, 1, transmitter busy flag.
- grant_active, output, 1, a packet grant is held.
- grant_id, output, $clog2(NUM_REQ), index of the current or last granted requester.
- err_timeout, output, 1, one-cycle pulse: transmitter did not go busy within BUSY_TIMEOUT.

Behaviour:
- Reset values: req_ready=0, uart_tx_start=0, uart_byte=8'h00, grant_active=0, grant_id=0, err_timeout=0, rr pointer=NUM_REQ-1, state=IDLE.
- States: IDLE, LAUNCH_HDR, LAUNCH_DATA, WAIT_BUSY, WAIT_DONE, WAIT_DATA.
- IDLE:
  - If any req_valid bit is set, choose the first set index searching upward from rr_ptr+1 (mod NUM_REQ).
  - Register the choice into grant_id and set grant_active=1.
  - Next state is LAUNCH_HDR if HDR_EN, else LAUNCH_DATA.
  - Arbitration costs exactly one cycle.
- LAUNCH_HDR (one cycle): uart_byte=HDR_BASE|grant_id, uart_tx_start=1, pkt_end=0, then WAIT_BUSY.
- LAUNCH_DATA (one cycle, entered only with req_valid[g]=1 for granted requester g):
  - uart_byte=req_data[g], uart_tx_start=1, req_ready[g]=1.
  - pkt_end latched from req_last[g]; then WAIT_BUSY.
- WAIT_BUSY:
  - A cycle counter starts at 0 on entry.
  - uart_tx_busy=1 moves to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT-1 with busy still low: pulse err_timeout, clear grant_active, set rr_ptr=g, go to IDLE. The rest of that packet is abandoned; the requester re-competes.
- WAIT_DONE, on uart_tx_busy=0:
  - If pkt_end: clear grant_active, set rr_ptr=g, go to IDLE.
  - Else if req_valid[g]: go to LAUNCH_DATA.
  - Else: go to WAIT_DATA.
- WAIT_DATA:
  - Grant stays locked; other requesters are ignored.
  - req_valid[g] moves to LAUNCH_DATA.
- Only the granted requester ever sees req_ready. Its req_data/req_last are sampled in the req_ready cycle only.
- Simultaneous requests in IDLE resolve purely by the rr pointer. A requester that just finished has lowest priority next round.
- The engine takes several clk cycles to raise busy, so busy is never sampled in the launch cycle.
- The rr pointer wraps NUM_REQ-1 → 0.
- rst mid-packet: immediate return to reset values.
  - A byte already handed to the engine is not retracted.
  - No req_ready is issued for a byte the controller has not launched.

Test Plan:
- Single requester: req0 sends 3 bytes 11,22,33 with last on 33, HDR_EN=1 → uart_byte sequence A0,11,22,33. Exactly 3 req_ready[0] pulses, 4 uart_tx_start pulses, grant_active falls after the final busy drop.
- Contention: req1 and req3 both valid in IDLE, rr_ptr=3 (reset) → req1 granted first (first set index above 0). req3 is not granted until req1's last byte completes. Next round with both valid → req3 first.
- Packet lock: req2 mid-packet with valid dropped for 20 cycles while req0 valid → state WAIT_DATA, no req_ready[0] pulses, req2 packet resumes.
- Timeout: model holds uart_tx_busy=0 → err_timeout pulses exactly BUSY_TIMEOUT cycles after uart_tx_start. grant_active=0, state returns to IDLE, next arbitration skips the failed requester if others are valid.
- HDR_EN=0, NUM_REQ=2: single-byte packets alternating req0/req1 continuously valid → strict alternation, no header bytes, uart_byte equals req_data.
- Reset mid-packet: assert rst during WAIT_DONE of byte 2 of 4 → all outputs at reset values next clk. After release, fresh arbitration with no stale req_ready.
